matmul_sequencer: RTL and testbench

- Sequences one N×N signed matrix multiply C = A·B over the three on-chip memories MEM_A, MEM_B and MEM_C.
- Generates read addresses for MEM_A and MEM_B, runs a single MAC at one product per cycle, and writes each finished C element to MEM_C.
- Sits under Top_controller; its start/done pair connects directly to the top-level start/done.

---
 rtl/matmul_sequencer.sv | 178 +++++++++++++++++
 tb/tb_matmul_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: sequences one NxN signed matrix multiply C = A*B.
// Issues one (i,j,k) read per cycle to MEM_A/MEM_B, accumulates one product
// per cycle and writes each finished C element to MEM_C.
// Ports:
//   clk, rstn          clock; synchronous active-high reset
//   start              run request, sampled only in IDLE
//   busy, done         run in progress; one-cycle completion pulse
//   a_re/a_addr/a_rdata  MEM_A read port, address i*N+k, data one cycle later
//   b_re/b_addr/b_rdata  MEM_B read port, address k*N+j, data one cycle later
//   c_we/c_addr/c_wdata  MEM_C write port, address i*N+j
module matmul_sequencer #(
  parameter int unsigned N    = 64,
  parameter int unsigned LOGN = 6,
  parameter int unsigned AW   = 12,
  parameter int unsigned DW   = 8,
  parameter int unsigned ACCW = 22
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            a_re,
  output logic [AW-1:0]   a_addr,
  input  logic [DW-1:0]   a_rdata,
  output logic            b_re,
  output logic [AW-1:0]   b_addr,
  input  logic [DW-1:0]   b_rdata,
  output logic            c_we,
  output logic [AW-1:0]   c_addr,
  output logic [ACCW-1:0] c_wdata
);

  localparam int unsigned PW = 2 * DW;
  localparam logic [LOGN-1:0] IDX_MAX = LOGN'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_d;

  // Current issue indices; a_addr/b_addr always hold the matching addresses.
  logic [LOGN-1:0] i, j, k;
  logic [LOGN-1:0] i_d, j_d, k_d;
  logic [LOGN-1:0] ni, nj, nk;
  logic            busy_d, done_d, re_d;
  logic [AW-1:0]   a_addr_d, b_addr_d;

  // Data-cycle tags, aligned with the read data.
  logic            p_valid, p_first, p_last;
  logic [AW-1:0]   p_caddr;
  logic [ACCW-1:0] acc, acc_sum;
  logic signed [PW-1:0] prod;

  // Counter step: k fastest, then j, then i.
  always_comb begin
    nk = k + 1'b1;
    nj = (k == IDX_MAX) ? j + 1'b1 : j;
    ni = (k == IDX_MAX && j == IDX_MAX) ? i + 1'b1 : i;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state;
    i_d      = i;
    j_d      = j;
    k_d      = k;
    busy_d   = busy;
    done_d   = 1'b0;
    re_d     = 1'b0;
    a_addr_d = '0;
    b_addr_d = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          busy_d  = 1'b1;
          re_d    = 1'b1;
        end
      end
      S_RUN: begin
        i_d = ni;
        j_d = nj;
        k_d = nk;
        if (i == IDX_MAX && j == IDX_MAX && k == IDX_MAX) begin
          state_d = S_DRAIN;
        end else begin
          re_d     = 1'b1;
          a_addr_d = AW'({ni, nk});
          b_addr_d = AW'({nk, nj});
        end
      end
      S_DRAIN: begin
        // The final write is the only one with nothing left in the data stage.
        if (c_we && !p_valid) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and issue-side registers.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state  <= S_IDLE;
      i      <= '0;
      j      <= '0;
      k      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      a_re   <= 1'b0;
      b_re   <= 1'b0;
      a_addr <= '0;
      b_addr <= '0;
    end else begin
      state  <= state_d;
      i      <= i_d;
      j      <= j_d;
      k      <= k_d;
      busy   <= busy_d;
      done   <= done_d;
      a_re   <= re_d;
      b_re   <= re_d;
      a_addr <= a_addr_d;
      b_addr <= b_addr_d;
    end
  end

  // MAC: signed product, sign-extended, summed modulo 2^ACCW.
  always_comb begin
    prod    = $signed(a_rdata) * $signed(b_rdata);
    acc_sum = (p_first ? '0 : acc) + {{(ACCW - PW){prod[PW-1]}}, prod};
  end

  // Tag pipeline, accumulator and writeback.
  always_ff @(posedge clk) begin
    if (rstn) begin
      p_valid <= 1'b0;
      p_first <= 1'b0;
      p_last  <= 1'b0;
      p_caddr <= '0;
      acc     <= '0;
      c_we    <= 1'b0;
      c_addr  <= '0;
      c_wdata <= '0;
    end else begin
      p_valid <= a_re;
      p_first <= a_re && (k == '0);
      p_last  <= a_re && (k == IDX_MAX);
      p_caddr <= AW'({i, j});
      if (p_valid) begin
        acc <= acc_sum;
      end
      c_we <= p_valid && p_last;
      if (p_valid && p_last) begin
        c_addr  <= p_caddr;
        c_wdata <= acc_sum;
      end
    end
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench for matmul_sequencer at N=4 with behavioural memories
// and a plain-arithmetic matrix-product reference.
module tb_matmul_sequencer;

  localparam int unsigned N    = 4;
  localparam int unsigned LOGN = 2;
  localparam int unsigned AW   = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned ACCW = 22;
  localparam int NN = 16;
  localparam int N3 = 64;

  logic            clk = 1'b0;
  logic            rstn = 1'b1;
  logic            start = 1'b0;
  logic            busy, done, a_re, b_re, c_we;
  logic [AW-1:0]   a_addr, b_addr, c_addr;
  logic [DW-1:0]   a_rdata = '0, b_rdata = '0;
  logic [ACCW-1:0] c_wdata;

  always #5 clk = ~clk;

  matmul_sequencer #(.N(N), .LOGN(LOGN), .AW(AW), .DW(DW), .ACCW(ACCW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done),
    .a_re(a_re), .a_addr(a_addr), .a_rdata(a_rdata),
    .b_re(b_re), .b_addr(b_addr), .b_rdata(b_rdata),
    .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata)
  );

  logic [DW-1:0] mem_a [NN];
  logic [DW-1:0] mem_b [NN];

  // Synchronous-read memories: data one cycle after the enable.
  always @(posedge clk) begin
    if (a_re) a_rdata <= mem_a[a_addr];
    if (b_re) b_rdata <= mem_b[b_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [ACCW-1:0] wr_data [NN];
  int              wr_cyc  [NN];
  logic [ACCW-1:0] ref_c   [NN];
  int wr_cnt, wr_late, done_cnt, done_cyc, busy_first, busy_last, busy_gap;
  int issue_cnt, issue_bad;
  logic busy_after, re_after;

  // Reference C = A*B using integer arithmetic, wrapped to ACCW bits.
  task automatic model();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        int s = 0;
        for (int q = 0; q < N; q++)
          s += int'($signed(mem_a[r*N+q])) * int'($signed(mem_b[q*N+c]));
        ref_c[r*N+c] = ACCW'(s);
      end
  endtask

  task automatic fill_random();
    for (int e = 0; e < NN; e++) begin
      mem_a[e] = DW'($urandom);
      mem_b[e] = DW'($urandom);
    end
  endtask

  // Drives one run (start in cycle 0) and records what the DUT does, cycle by cycle.
  task automatic run(input int p0, input int p1, input int p2, input int rst_at,
                     input bit hold, input int limit);
    wr_cnt = 0; wr_late = 0; done_cnt = 0; done_cyc = -1;
    busy_first = -1; busy_last = -1; busy_gap = 0;
    issue_cnt = 0; issue_bad = 0; busy_after = 1'bx; re_after = 1'bx;
    for (int e = 0; e < NN; e++) begin
      wr_data[e] = '0;
      wr_cyc[e]  = -1;
    end
    @(posedge clk); #1;
    for (int c = 0; c < limit; c++) begin
      bit exp_re;
      start = hold || c == 0 || c == p0 || c == p1 || c == p2;
      rstn  = (c == rst_at);
      @(negedge clk);
      if (done_cnt > 0 && c == done_cyc + 2) begin
        busy_after = busy;
        re_after   = a_re;
        break;
      end
      if (c_we) begin
        wr_cnt++;
        wr_data[c_addr] = c_wdata;
        wr_cyc[c_addr]  = c;
        if (rst_at >= 0 && c > rst_at) wr_late++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (busy) begin
        if (busy_first < 0) busy_first = c;
        else if (busy_last != c - 1) busy_gap++;
        busy_last = c;
      end
      exp_re = (c >= 1) && (c <= N3) && (rst_at < 0 || c <= rst_at);
      if (a_re !== exp_re || b_re !== exp_re) issue_bad++;
      if (a_re === 1'b1) begin
        int m = issue_cnt;
        int ea = (m / (N*N)) * N + (m % N);
        int eb = (m % N) * N + (m / N) % N;
        if (a_addr !== AW'(ea) || b_addr !== AW'(eb)) issue_bad++;
        issue_cnt++;
      end else if (a_addr !== '0 || b_addr !== '0) begin
        issue_bad++;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    rstn  = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    start = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      n_tests++;
      if ({busy, done, a_re, b_re, c_we} !== 5'b0 || a_addr !== '0 || b_addr !== '0 ||
          c_addr !== '0 || c_wdata !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d got busy=%b done=%b are=%b bre=%b cwe=%b aa=%h ba=%h ca=%h cd=%h want all 0",
                 c, busy, done, a_re, b_re, c_we, a_addr, b_addr, c_addr, c_wdata);
      end
    end
    rstn = 1'b0;
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if ({busy, a_re, c_we, done} !== 4'b0) begin
        n_fail++;
        $display("FAIL reset_idle got busy=%b are=%b cwe=%b done=%b want 0", busy, a_re, c_we, done);
      end
    end
  endtask

  task automatic test_identity();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        mem_a[r*N+c] = (r == c) ? DW'(1) : DW'(0);
        mem_b[r*N+c] = DW'(r*N+c);
      end
    model();
    run(-1, -1, -1, -1, 1'b0, 200);
    n_tests++;
    if (wr_cnt !== 16) begin n_fail++; $display("FAIL id_wr_cnt got %0d want 16", wr_cnt); end
    n_tests++;
    if (wr_cyc[0] !== 6 || wr_data[0] !== '0) begin
      n_fail++; $display("FAIL id_first_write got cyc=%0d data=%h want cyc=6 data=0", wr_cyc[0], wr_data[0]);
    end
    for (int e = 0; e < NN; e++) begin
      n_tests++;
      if (wr_data[e] !== ref_c[e] || wr_cyc[e] !== (e + 1) * N + 2) begin
        n_fail++;
        $display("FAIL id_elem %0d got data=%h cyc=%0d want data=%h cyc=%0d",
                 e, wr_data[e], wr_cyc[e], ref_c[e], (e + 1) * N + 2);
      end
    end
    n_tests++;
    if (done_cnt !== 1 || done_cyc !== 67) begin
      n_fail++; $display("FAIL id_done got count=%0d cyc=%0d want 1 at 67", done_cnt, done_cyc);
    end
    n_tests++;
    if (busy_first !== 1 || busy_last !== 67 || busy_gap !== 0) begin
      n_fail++; $display("FAIL id_busy got %0d..%0d gaps=%0d want 1..67 gaps=0", busy_first, busy_last, busy_gap);
    end
    n_tests++;
    if (issue_cnt !== N3 || issue_bad !== 0) begin
      n_fail++; $display("FAIL id_issue got count=%0d bad=%0d want 64 bad=0", issue_cnt, issue_bad);
    end
    n_tests++;
    if (busy_after !== 1'b0 || re_after !== 1'b0) begin
      n_fail++; $display("FAIL id_no_restart got busy=%b are=%b want 0", busy_after, re_after);
    end
  endtask

  task automatic test_extremes();
    logic [ACCW-1:0] want [2];
    want[0] = 22'h010000;
    want[1] = 22'h3F0200;
    for (int t = 0; t < 2; t++) begin
      for (int e = 0; e < NN; e++) begin
        mem_a[e] = 8'h80;
        mem_b[e] = (t == 0) ? 8'h80 : 8'h7F;
      end
      run(-1, -1, -1, -1, 1'b0, 200);
      for (int e = 0; e < NN; e++) begin
        n_tests++;
        if (wr_data[e] !== want[t]) begin
          n_fail++; $display("FAIL extreme%0d elem %0d got %h want %h", t, e, wr_data[e], want[t]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 3; t++) begin
      fill_random();
      model();
      run(-1, -1, -1, -1, 1'b0, 200);
      for (int e = 0; e < NN; e++) begin
        n_tests++;
        if (wr_data[e] !== ref_c[e] || wr_cyc[e] !== (e + 1) * N + 2) begin
          n_fail++;
          $display("FAIL rand%0d elem %0d got data=%h cyc=%0d want data=%h cyc=%0d",
                   t, e, wr_data[e], wr_cyc[e], ref_c[e], (e + 1) * N + 2);
        end
      end
      n_tests++;
      if (done_cnt !== 1 || done_cyc !== 67 || issue_bad !== 0) begin
        n_fail++; $display("FAIL rand%0d_done got count=%0d cyc=%0d bad=%0d want 1 at 67 bad=0",
                           t, done_cnt, done_cyc, issue_bad);
      end
    end
  endtask

  task automatic test_start_ignored();
    fill_random();
    model();
    run(10, 40, 67, -1, 1'b0, 200);
    n_tests++;
    if (done_cnt !== 1 || done_cyc !== 67 || wr_cnt !== 16) begin
      n_fail++; $display("FAIL ign_done got count=%0d cyc=%0d writes=%0d want 1 at 67 writes=16",
                         done_cnt, done_cyc, wr_cnt);
    end
    n_tests++;
    if (busy_first !== 1 || busy_last !== 67 || busy_gap !== 0 || busy_after !== 1'b0) begin
      n_fail++; $display("FAIL ign_busy got %0d..%0d gaps=%0d after=%b want 1..67 gaps=0 after=0",
                         busy_first, busy_last, busy_gap, busy_after);
    end
    for (int e = 0; e < NN; e++) begin
      n_tests++;
      if (wr_data[e] !== ref_c[e]) begin
        n_fail++; $display("FAIL ign_elem %0d got %h want %h", e, wr_data[e], ref_c[e]);
      end
    end
  endtask

  task automatic test_reset_midrun();
    fill_random();
    run(-1, -1, -1, 30, 1'b0, 100);
    n_tests++;
    if (wr_late !== 0 || done_cnt !== 0) begin
      n_fail++; $display("FAIL mid_abort got late_writes=%0d dones=%0d want 0 0", wr_late, done_cnt);
    end
    n_tests++;
    if (busy_last !== 30 || issue_cnt !== 30 || issue_bad !== 0) begin
      n_fail++; $display("FAIL mid_stop got busy_last=%0d issues=%0d bad=%0d want 30 30 0",
                         busy_last, issue_cnt, issue_bad);
    end
    fill_random();
    model();
    run(-1, -1, -1, -1, 1'b0, 200);
    n_tests++;
    if (done_cnt !== 1 || done_cyc !== 67 || wr_cnt !== 16) begin
      n_fail++; $display("FAIL mid_rerun got count=%0d cyc=%0d writes=%0d want 1 at 67 writes=16",
                         done_cnt, done_cyc, wr_cnt);
    end
    for (int e = 0; e < NN; e++) begin
      n_tests++;
      if (wr_data[e] !== ref_c[e]) begin
        n_fail++; $display("FAIL mid_elem %0d got %h want %h", e, wr_data[e], ref_c[e]);
      end
    end
  endtask

  task automatic test_back_to_back();
    fill_random();
    model();
    run(-1, -1, -1, -1, 1'b1, 200);
    n_tests++;
    if (done_cnt !== 1 || done_cyc !== 67) begin
      n_fail++; $display("FAIL b2b_done got count=%0d cyc=%0d want 1 at 67", done_cnt, done_cyc);
    end
    n_tests++;
    if (busy_after !== 1'b1 || re_after !== 1'b1) begin
      n_fail++; $display("FAIL b2b_restart got busy=%b are=%b want 1 1", busy_after, re_after);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
    rstn = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || c_we !== 1'b0) begin
      n_fail++; $display("FAIL b2b_reset got busy=%b cwe=%b want 0 0", busy, c_we);
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_extremes();
    test_random();
    test_start_ignored();
    test_reset_midrun();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
